// File: rtl/assoc_tag_lookup_pkg.sv
// rtl/assoc_tag_lookup_pkg.sv - shared types and tree-PLRU helper functions
package assoc_tag_lookup_pkg;

    localparam int MAX_WAYS  = 8;
    localparam int MAX_NODES = MAX_WAYS - 1;

    typedef logic [MAX_WAYS-1:0]  way_vec_t;
    typedef logic [MAX_NODES-1:0] plru_bits_t;

    function automatic int tree_depth(input int ways);
        return (ways >= 8) ? 3 : ((ways >= 4) ? 2 : 1);
    endfunction

    function automatic int onehot_to_index(input way_vec_t v);
        int idx;
        idx = 0;
        for (int w = 0; w < MAX_WAYS; w++)
            if (v[w]) idx = w;
        return idx;
    endfunction

    // Walk from the root following each node's bit; the leaf offset is the victim way.
    function automatic int plru_victim(input plru_bits_t bits, input int ways);
        int node;
        node = 0;
        for (int l = 0; l < 3; l++)
            if (l < tree_depth(ways))
                node = 2 * node + 1 + int'(bits[node[2:0]]);
        return node - (ways - 1);
    endfunction

    function automatic plru_bits_t plru_next(input plru_bits_t bits, input int way, input int ways);
        plru_bits_t nb;
        int         node;
        int         depth;
        int         dir;
        nb    = bits;
        node  = 0;
        depth = tree_depth(ways);
        for (int l = 0; l < 3; l++) begin
            if (l < depth) begin
                dir = (way >> (depth - 1 - l)) & 1;
                nb[node[2:0]] = (dir == 0);
                node = 2 * node + 1 + dir;
            end
        end
        return nb;
    endfunction

endpackage

// File: rtl/assoc_tag_lookup_if.sv
// rtl/assoc_tag_lookup_if.sv - lookup, fill and response signals of the tag store
interface assoc_tag_lookup_if #(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int TAG_W = 9
);
    localparam int IDX_W = $clog2(SETS);

    logic             lk_valid;
    logic [IDX_W-1:0] lk_index;
    logic [TAG_W-1:0] lk_tag;
    logic             fill_valid;
    logic [IDX_W-1:0] fill_index;
    logic [WAYS-1:0]  fill_way;
    logic [TAG_W-1:0] fill_tag;
    logic             inval_all;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [WAYS-1:0]  rsp_way;
    logic [WAYS-1:0]  rsp_victim;
    logic             rsp_multi_hit;

    modport master (
        output lk_valid, lk_index, lk_tag, fill_valid, fill_index, fill_way, fill_tag, inval_all,
        input  rsp_valid, rsp_hit, rsp_way, rsp_victim, rsp_multi_hit
    );

    modport slave (
        input  lk_valid, lk_index, lk_tag, fill_valid, fill_index, fill_way, fill_tag, inval_all,
        output rsp_valid, rsp_hit, rsp_way, rsp_victim, rsp_multi_hit
    );

endinterface

// File: rtl/assoc_tag_lookup_plru.sv
// rtl/assoc_tag_lookup_plru.sv - per-set tree-PLRU bits with hit/fill touch and victim read
module assoc_tag_lookup_plru
    import assoc_tag_lookup_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hit_valid,
    input  logic [IDX_W-1:0] hit_index,
    input  logic [WAYS-1:0]  hit_way,
    input  logic             fill_valid,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [WAYS-1:0]  fill_way,
    input  logic [IDX_W-1:0] rd_index,
    output logic [WAYS-1:0]  rd_victim
);
    localparam int NODES = WAYS - 1;

    logic [NODES-1:0] plru_q [SETS];

    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] bits, input logic [WAYS-1:0] way);
        return NODES'(plru_next(plru_bits_t'(bits), onehot_to_index(way_vec_t'(way)), WAYS));
    endfunction

    assign rd_victim = WAYS'(1) << plru_victim(plru_bits_t'(plru_q[rd_index]), WAYS);

    // A fill to the same set replaces the hit's touch rather than composing with it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int s = 0; s < SETS; s++)
                plru_q[s] <= '0;
        end else begin
            if (hit_valid && !(fill_valid && (fill_index == hit_index)))
                plru_q[hit_index] <= touch(plru_q[hit_index], hit_way);
            if (fill_valid)
                plru_q[fill_index] <= touch(plru_q[fill_index], fill_way);
        end
    end

endmodule

// File: rtl/assoc_tag_lookup.sv
// rtl/assoc_tag_lookup.sv - N-way set-associative tag store with registered hit and PLRU victim
module assoc_tag_lookup
    import assoc_tag_lookup_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int TAG_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    assoc_tag_lookup_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;

    logic [WAYS-1:0] valid_q [SETS];
    tag_t            tag_q   [SETS][WAYS];

    logic [WAYS-1:0] match;
    logic [WAYS-1:0] lowest_match;
    logic [WAYS-1:0] invalid_ways;
    logic [WAYS-1:0] lowest_invalid;
    logic [WAYS-1:0] plru_way;
    logic [WAYS-1:0] victim;
    logic            hit;
    logic            multi;
    logic            fill_en;
    idx_t            lk_idx;

    logic            rsp_valid_q;
    logic            rsp_hit_q;
    logic [WAYS-1:0] rsp_way_q;
    logic [WAYS-1:0] rsp_victim_q;
    logic            rsp_multi_q;

    assign lk_idx  = bus.lk_index;
    assign fill_en = bus.fill_valid && (bus.fill_way != '0);

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == bus.lk_tag);
    end

    assign hit            = |match;
    assign multi          = $countones(match) > 1;
    assign lowest_match   = match & (~match + WAYS'(1));
    assign invalid_ways   = ~valid_q[lk_idx];
    assign lowest_invalid = invalid_ways & (~invalid_ways + WAYS'(1));
    assign victim         = (|invalid_ways) ? lowest_invalid : plru_way;

    assoc_tag_lookup_plru #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_plru (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.inval_all),
        .hit_valid  (bus.lk_valid && hit),
        .hit_index  (lk_idx),
        .hit_way    (lowest_match),
        .fill_valid (fill_en),
        .fill_index (bus.fill_index),
        .fill_way   (bus.fill_way),
        .rd_index   (lk_idx),
        .rd_victim  (plru_way)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++)
                valid_q[s] <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_victim_q <= '0;
            rsp_multi_q  <= 1'b0;
        end else begin
            rsp_valid_q  <= bus.lk_valid;
            rsp_hit_q    <= bus.lk_valid && hit;
            rsp_way_q    <= bus.lk_valid ? lowest_match : '0;
            rsp_victim_q <= bus.lk_valid ? victim : '0;
            rsp_multi_q  <= bus.lk_valid && multi;
            if (bus.inval_all) begin
                for (int s = 0; s < SETS; s++)
                    valid_q[s] <= '0;
            end else if (fill_en) begin
                valid_q[bus.fill_index] <= valid_q[bus.fill_index] | bus.fill_way;
            end
        end
    end

    // Tag contents are meaningless while invalid, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (fill_en && !bus.inval_all) begin
            for (int w = 0; w < WAYS; w++)
                if (bus.fill_way[w])
                    tag_q[bus.fill_index][w] <= bus.fill_tag;
        end
    end

    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_hit       = rsp_hit_q;
    assign bus.rsp_way       = rsp_way_q;
    assign bus.rsp_victim    = rsp_victim_q;
    assign bus.rsp_multi_hit = rsp_multi_q;

    fill_onehot_a: assert property (@(posedge clk) disable iff (reset)
        bus.fill_valid |-> $onehot0(bus.fill_way));

endmodule
